// File: rtl/fixed_pkg.sv
// fixed_pkg: shared constants, types and special-code helpers
// for the pipelined signed fixed-point multiplier.
package fixed_pkg;

    localparam int FX_MAX_W = 256;

    localparam int FLG_NAN = 0;
    localparam int FLG_OVF = 1;
    localparam int FLG_INX = 2;

    localparam int RND_TRUNC   = 0;
    localparam int RND_HALF_UP = 1;

    typedef logic [2:0] flags_t;

    typedef enum logic [1:0] {
        K_FIN = 2'd0,
        K_NAN = 2'd1,
        K_INF = 2'd2
    } kind_t;

    // NAN: sign bit alone set.
    function automatic logic [FX_MAX_W-1:0] fx_nan(input int w);
        return FX_MAX_W'(1) << (w - 1);
    endfunction

    // POS_INF: largest positive code.
    function automatic logic [FX_MAX_W-1:0] fx_pos_inf(input int w);
        return fx_nan(w) - FX_MAX_W'(1);
    endfunction

    // NEG_INF: one above NAN.
    function automatic logic [FX_MAX_W-1:0] fx_neg_inf(input int w);
        return fx_nan(w) + FX_MAX_W'(1);
    endfunction

endpackage

// File: rtl/fixed_decode.sv
// fixed_decode: combinational classifier for one operand word,
// reporting sign and the NAN / INF / ZERO special codes.
module fixed_decode
    import fixed_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] word,
    output logic             sign,
    output logic             nan,
    output logic             inf,
    output logic             zero
);

    localparam logic [WIDTH-1:0] NAN_C  = WIDTH'(fx_nan(WIDTH));
    localparam logic [WIDTH-1:0] PINF_C = WIDTH'(fx_pos_inf(WIDTH));
    localparam logic [WIDTH-1:0] NINF_C = WIDTH'(fx_neg_inf(WIDTH));

    assign sign = word[WIDTH-1];
    assign nan  = (word == NAN_C);
    assign inf  = (word == PINF_C) || (word == NINF_C);
    assign zero = (word == '0);

endmodule

// File: rtl/fixed_mul_pipe.sv
// fixed_mul_pipe: three-stage signed fixed-point multiplier with
// valid/ready handshakes, tag pass-through and sticky exception status.
module fixed_mul_pipe
    import fixed_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int FRAC  = 48,
    parameter int ROUND = 0,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic [2:0]       out_flags,
    input  logic             status_clr,
    output logic [2:0]       status
);

    localparam int W2 = 2 * WIDTH;

    localparam logic [WIDTH-1:0] NAN_C  = WIDTH'(fx_nan(WIDTH));
    localparam logic [WIDTH-1:0] PINF_C = WIDTH'(fx_pos_inf(WIDTH));
    localparam logic [WIDTH-1:0] NINF_C = WIDTH'(fx_neg_inf(WIDTH));

    localparam logic signed [W2-1:0] MAX_FIN =
        W2'(PINF_C - WIDTH'(1));
    localparam logic signed [W2-1:0] MIN_FIN = -MAX_FIN;
    localparam logic signed [W2-1:0] RND_ADD =
        (ROUND == RND_HALF_UP) ? (W2'(1) << (FRAC - 1)) : '0;

    logic adv1;
    logic adv2;
    logic adv3;
    logic v1;
    logic v2;

    logic a_sign, a_nan, a_inf, a_zero;
    logic b_sign, b_nan, b_inf, b_zero;
    kind_t in_kind;
    logic  in_sign;

    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [TAG_W-1:0] s1_tag;
    kind_t            s1_kind;
    logic             s1_sign;

    logic signed [W2-1:0] a_ext;
    logic signed [W2-1:0] b_ext;
    logic signed [W2-1:0] prod_c;

    logic signed [W2-1:0] s2_prod;
    logic [TAG_W-1:0]     s2_tag;
    kind_t                s2_kind;
    logic                 s2_sign;

    logic signed [W2-1:0] rnd_sum;
    logic signed [W2-1:0] shifted;
    logic                 out_range;
    logic                 inexact;
    logic [WIDTH-1:0]     sat_val;
    logic [WIDTH-1:0]     res_c;
    flags_t               flags_c;

    fixed_decode #(.WIDTH(WIDTH)) u_dec_a (
        .word (in_a),
        .sign (a_sign),
        .nan  (a_nan),
        .inf  (a_inf),
        .zero (a_zero)
    );

    fixed_decode #(.WIDTH(WIDTH)) u_dec_b (
        .word (in_b),
        .sign (b_sign),
        .nan  (b_nan),
        .inf  (b_inf),
        .zero (b_zero)
    );

    // Backpressure chain: a stage moves when empty or its successor moves.
    assign adv3     = !out_valid || out_ready;
    assign adv2     = !v2 || adv3;
    assign adv1     = !v1 || adv2;
    assign in_ready = !v1 || adv1;

    // Reduce the operand classes to one kind code; NAN beats INF.
    always_comb begin
        in_kind = K_FIN;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            in_kind = K_NAN;
        end else if (a_inf || b_inf) begin
            in_kind = K_INF;
        end
    end

    assign in_sign = a_sign ^ b_sign;

    // S1: capture operands, tag and their special-case kind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_tag  <= '0;
            s1_kind <= K_FIN;
            s1_sign <= 1'b0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_a    <= in_a;
                s1_b    <= in_b;
                s1_tag  <= in_tag;
                s1_kind <= in_kind;
                s1_sign <= in_sign;
            end
        end
    end

    assign a_ext  = {{WIDTH{s1_a[WIDTH-1]}}, s1_a};
    assign b_ext  = {{WIDTH{s1_b[WIDTH-1]}}, s1_b};
    assign prod_c = a_ext * b_ext;

    // S2: register the full double-width signed product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            s2_prod <= '0;
            s2_tag  <= '0;
            s2_kind <= K_FIN;
            s2_sign <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                s2_prod <= prod_c;
                s2_tag  <= s1_tag;
                s2_kind <= s1_kind;
                s2_sign <= s1_sign;
            end
        end
    end

    assign rnd_sum   = s2_prod + RND_ADD;
    assign shifted   = rnd_sum >>> FRAC;
    assign out_range = (shifted > MAX_FIN) || (shifted < MIN_FIN);
    assign inexact   = |s2_prod[FRAC-1:0];
    assign sat_val   = s2_sign ? NINF_C : PINF_C;

    // S3 select: specials first, then saturate or pass the scaled value.
    always_comb begin
        res_c   = shifted[WIDTH-1:0];
        flags_c = '0;
        unique case (s2_kind)
            K_NAN: begin
                res_c            = NAN_C;
                flags_c[FLG_NAN] = 1'b1;
            end
            K_INF: begin
                res_c            = sat_val;
                flags_c[FLG_OVF] = 1'b1;
            end
            default: begin
                if (out_range) begin
                    res_c            = sat_val;
                    flags_c[FLG_OVF] = 1'b1;
                end else begin
                    flags_c[FLG_INX] = inexact;
                end
            end
        endcase
    end

    // S3: output register, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_res   <= '0;
            out_tag   <= '0;
            out_flags <= '0;
        end else if (adv3) begin
            out_valid <= v2;
            if (v2) begin
                out_res   <= res_c;
                out_tag   <= s2_tag;
                out_flags <= flags_c;
            end
        end
    end

    // Sticky status; a flag delivered alongside a clear still lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= '0;
        end else begin
            status <= (status_clr ? 3'b000 : status)
                    | ((out_valid && out_ready) ? out_flags : 3'b000);
        end
    end

endmodule

// File: tb/tb_fixed_mul_pipe.sv
// tb_fixed_mul_pipe: scoreboard bench running a truncating and a
// rounding instance side by side on the same operand stream.
module tb_fixed_mul_pipe;

    localparam logic [63:0] NAN  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] PINF = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] NINF = 64'h8000_0000_0000_0001;
    localparam logic [63:0] ONE  = 64'h0001_0000_0000_0000;
    localparam logic [63:0] MONE = 64'hFFFF_0000_0000_0000;
    localparam logic [63:0] HALF = 64'h0000_8000_0000_0000;
    localparam logic signed [127:0] LIM = 128'sh7FFF_FFFF_FFFF_FFFE;

    typedef struct packed {
        logic [63:0] res;
        logic [3:0]  tag;
        logic [2:0]  flags;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic [3:0]  in_tag = '0;
    logic        out_ready = 1'b1;
    logic        status_clr = 1'b0;
    logic        rand_bp = 1'b0;

    logic        ir0, ov0, ir1, ov1;
    logic [63:0] res0, res1;
    logic [3:0]  tag0, tag1;
    logic [2:0]  fl0, fl1, st0, st1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [2:0]  est[2]  = '{3'b0, 3'b0};
    logic        hold[2] = '{1'b0, 1'b0};
    logic [63:0] pres[2];
    logic [3:0]  ptag[2];
    logic [2:0]  pfl[2];

    always #5 clk = ~clk;

    fixed_mul_pipe #(.WIDTH(64), .FRAC(48), .ROUND(0), .TAG_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(ov0), .out_ready(out_ready), .out_res(res0),
        .out_tag(tag0), .out_flags(fl0),
        .status_clr(status_clr), .status(st0)
    );

    fixed_mul_pipe #(.WIDTH(64), .FRAC(48), .ROUND(1), .TAG_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(ov1), .out_ready(out_ready), .out_res(res1),
        .out_tag(tag1), .out_flags(fl1),
        .status_clr(status_clr), .status(st1)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: exact integer product, then the result rules in order.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic [3:0] tag, input bit rnd);
        exp_t e;
        logic signed [127:0] pa, pb, p, q;
        logic an, bn, ai, bi, az, bz, sg;
        e.tag   = tag;
        e.flags = 3'b000;
        e.res   = '0;
        an = (a == NAN);
        bn = (b == NAN);
        ai = (a == PINF) || (a == NINF);
        bi = (b == PINF) || (b == NINF);
        az = (a == 0);
        bz = (b == 0);
        sg = a[63] ^ b[63];
        if (an || bn || (ai && bz) || (bi && az)) begin
            e.res   = NAN;
            e.flags = 3'b001;
        end else if (ai || bi) begin
            e.res   = sg ? NINF : PINF;
            e.flags = 3'b010;
        end else begin
            pa = $signed(a);
            pb = $signed(b);
            p  = pa * pb;
            q  = p;
            if (rnd) q = q + (128'sd1 <<< 47);
            q = q >>> 48;
            if (q > LIM || q < -LIM) begin
                e.res   = sg ? NINF : PINF;
                e.flags = 3'b010;
            end else begin
                e.res   = q[63:0];
                e.flags = {(p[47:0] != 0), 2'b00};
            end
        end
        return e;
    endfunction

    function automatic logic [63:0] rnd_op();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: case ($urandom_range(0, 3))
                   0: r = NAN;
                   1: r = PINF;
                   2: r = NINF;
                   default: r = '0;
               endcase
            1: r = r;
            2: r = 64'($signed(r[31:0])) << 24;
            3: r = 64'($signed(r[15:0]));
            4: case ($urandom_range(0, 4))
                   0: r = PINF - 64'd1;
                   1: r = NINF + 64'd1;
                   2: r = ONE;
                   3: r = MONE;
                   default: r = HALF;
               endcase
            default: r = 64'($signed(r[31:0])) << 16;
        endcase
        return r;
    endfunction

    // Offer one operation; returns on the negedge after it was taken.
    task automatic send(input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] t);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_tag = t;
        #1;
        while (!ir0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!ir0) begin
            chk("send_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            @(negedge clk);
        end else begin
            q0.push_back(model(a, b, t, 1'b0));
            q1.push_back(model(a, b, t, 1'b1));
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(q0.size() + q1.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_ov(input string name);
        int n;
        n = 0;
        #2;
        while (!ov0 && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!ov0) chk(name, 64'd0, 64'd1);
        @(negedge clk);
    endtask

    // Per-instance monitor: status, hold stability and in-order results.
    task automatic mon(input int d, input logic ov, input logic [63:0] r,
                       input logic [3:0] t, input logic [2:0] f,
                       input logic [2:0] st);
        exp_t e;
        logic [2:0] ef;
        logic empty;
        if (!rst_n) begin
            if (d == 0) q0.delete();
            else q1.delete();
            est[d]  = 3'b000;
            hold[d] = 1'b0;
            return;
        end
        chk($sformatf("status%0d", d), 64'(st), 64'(est[d]));
        if (hold[d]) begin
            chk($sformatf("held_valid%0d", d), 64'(ov), 64'd1);
            chk($sformatf("held_res%0d", d), r, pres[d]);
            chk($sformatf("held_tag%0d", d), 64'(t), 64'(ptag[d]));
            chk($sformatf("held_flags%0d", d), 64'(f), 64'(pfl[d]));
        end
        ef = 3'b000;
        if (ov && out_ready) begin
            empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out%0d: got tag %h, expected none", d, t);
            end else begin
                if (d == 0) e = q0.pop_front();
                else e = q1.pop_front();
                chk($sformatf("res%0d_tag%0h", d, e.tag), r, e.res);
                chk($sformatf("tag%0d", d), 64'(t), 64'(e.tag));
                chk($sformatf("flags%0d_tag%0h", d, e.tag), 64'(f), 64'(e.flags));
                ef = e.flags;
            end
        end
        est[d]  = (status_clr ? 3'b000 : est[d]) | ef;
        hold[d] = ov && !out_ready;
        pres[d] = r;
        ptag[d] = t;
        pfl[d]  = f;
    endtask

    always @(negedge clk) begin
        #4;
        mon(0, ov0, res0, tag0, fl0, st0);
        mon(1, ov1, res1, tag1, fl1, st1);
    end

    always @(negedge clk) begin
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int acc;
        logic [63:0] k;

        #1;
        chk("rst_out_valid0", 64'(ov0), 64'd0);
        chk("rst_out_valid1", 64'(ov1), 64'd0);
        chk("rst_res0", res0, 64'd0);
        chk("rst_tag0", 64'(tag0), 64'd0);
        chk("rst_flags0", 64'(fl0), 64'd0);
        chk("rst_status0", 64'(st0), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_rst0", 64'(ir0), 64'd1);
        chk("in_ready_after_rst1", 64'(ir1), 64'd1);
        @(negedge clk);

        out_ready = 1'b1;
        send(64'h0001_8000_0000_0000, 64'h0002_0000_0000_0000, 4'd1);
        in_valid = 1'b0;
        cnt = 1;
        #2;
        while (!ov0 && cnt < 10) begin
            @(negedge clk);
            #2;
            cnt++;
        end
        chk("latency", 64'(cnt), 64'd3);
        @(negedge clk);
        drain();

        send(64'h7000_0000_0000_0000, 64'h0002_0000_0000_0000, 4'd2);
        send(64'h9000_0000_0000_0000, 64'h0002_0000_0000_0000, 4'd3);
        send(NAN, ONE, 4'd4);
        send(PINF, 64'd0, 4'd5);
        send(NINF, MONE, 4'd6);
        send(64'd1, HALF, 4'd7);
        send(64'hFFFF_FFFF_FFFF_FFFF, HALF, 4'd8);
        send(PINF - 64'd1, ONE, 4'd9);
        in_valid = 1'b0;
        drain();

        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            k = 64'(acc + 1);
            in_valid = 1'b1;
            in_a = k << 48;
            in_b = 64'h0001_8000_0000_0000;
            in_tag = 4'(acc + 1);
            #1;
            if (ir0) begin
                q0.push_back(model(in_a, in_b, in_tag, 1'b0));
                q1.push_back(model(in_a, in_b, in_tag, 1'b1));
                acc++;
            end
            @(negedge clk);
        end
        chk("bp_accepted", 64'(acc), 64'd3);
        #1;
        chk("bp_in_ready0", 64'(ir0), 64'd0);
        chk("bp_in_ready1", 64'(ir1), 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        for (int t = acc + 1; t <= 5; t++) begin
            k = 64'(t);
            send(k << 48, 64'h0001_8000_0000_0000, 4'(t));
        end
        in_valid = 1'b0;
        drain();

        rand_bp = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end else begin
                send(rnd_op(), rnd_op(), 4'($urandom));
            end
        end
        in_valid = 1'b0;
        rand_bp = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        chk("status_pre_ovf", 64'(st0[1]), 64'd1);
        out_ready = 1'b0;
        send(NAN, ONE, 4'hA);
        in_valid = 1'b0;
        wait_ov("clr_setup");
        status_clr = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
        #1;
        chk("status_clr_nan0", 64'(st0), 64'd1);
        chk("status_clr_nan1", 64'(st1), 64'd1);
        @(negedge clk);
        drain();

        out_ready = 1'b0;
        send(64'h7000_0000_0000_0000, 64'h0002_0000_0000_0000, 4'hB);
        send(ONE, ONE, 4'hC);
        in_valid = 1'b0;
        wait_ov("rst_setup");
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid0", 64'(ov0), 64'd0);
        chk("midrst_out_valid1", 64'(ov1), 64'd0);
        chk("midrst_status0", 64'(st0), 64'd0);
        chk("midrst_status1", 64'(st1), 64'd0);
        chk("midrst_res0", res0, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready0", 64'(ir0), 64'd1);
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("leftover", 64'(q0.size() + q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
